dcache_controller: RTL and testbench
====================================

# dcache_controller

Direct-mapped, write-back, write-allocate data cache that sits between the CPU MEM stage and the `Data_Memory` block. It is the initiator side of the memory's enable/write/ack protocol. CPU hits complete in the same cycle without stalling. Misses stall the CPU while the controller writes back a dirty victim line and refills the line from memory.

## Interface
Parameters:
- `INDEX_BITS`, 4: set index width; the cache has 2^INDEX_BITS lines.
- `LINE_BITS`, 256: line width; must equal the memory unit width (`DM_UNIT_MASK`+1).
- `OFFSET_BITS`, 5: byte-offset width within a line, log2(LINE_BITS/8).
- `TAG_BITS`, 32-INDEX_BITS-OFFSET_BITS: tag width.

Ports (reset rst_i, asynchronous, active-low; clock clk_i):
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous active-low reset.
- `cpu_req_i` in 1: CPU access request.
- `cpu_write_i` in 1: 1 = store, 0 = load.
- `cpu_addr_i` in 32: byte address; word-aligned, bits [1:0] ignored.
- `cpu_data_i` in 32: store data.
- `cpu_data_o` out 32: load data; valid when `cpu_req_i`=1 and `cpu_stall_o`=0.
- `cpu_stall_o` out 1: combinational; 1 while the request is not yet a hit.
- `mem_enable_o` out 1: memory request.
- `mem_write_o` out 1: memory write.
- `mem_addr_o` out 32: line address, bits [OFFSET_BITS-1:0]=0.
- `mem_data_o` out LINE_BITS: write-back line data.
- `mem_data_i` in LINE_BITS: refill data; valid the cycle after `mem_ack_i`.
- `mem_ack_i` in 1: single-cycle completion pulse from memory.

## Operation
- Address split: tag = addr[31:OFFSET_BITS+INDEX_BITS]; index = addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS]; word = addr[OFFSET_BITS-1:2].
- Per-line storage: valid bit, dirty bit, tag, and LINE_BITS of data.
- hit = `cpu_req_i` & valid[index] & (tag[index]==tag) & state==IDLE.
- `cpu_stall_o` = `cpu_req_i` & ~hit.
- Read hit: `cpu_data_o` = line[index] word `word`, combinational.
- Write hit: at posedge, write `cpu_data_i` into the selected word and set dirty[index]=1.
- `cpu_data_o` is 0 when there is no hit.
- FSM states and transitions:
  - IDLE: on `cpu_req_i` & ~hit, go to WRITEBACK if valid&dirty, else go to ALLOCATE.
  - WRITEBACK: `mem_enable_o`=1, `mem_write_o`=1, `mem_addr_o`={stored tag, index, 0}, `mem_data_o`=line[index]. On `mem_ack_i`, go to ALLOCATE.
  - ALLOCATE: `mem_enable_o`=1, `mem_write_o`=0, `mem_addr_o`={cpu tag, index, 0}. On `mem_ack_i`, go to FILL.
  - FILL: `mem_enable_o`=0. At posedge, line[index]←`mem_data_i`, tag←cpu tag, valid=1, dirty=0; go to IDLE.
- After FILL, IDLE re-evaluates the request. It now hits, so a pending store is applied in that IDLE cycle.
- Outside WRITEBACK and ALLOCATE: `mem_enable_o`, `mem_write_o`, `mem_addr_o` and `mem_data_o` are all 0.
- Memory outputs are held constant for the whole WRITEBACK or ALLOCATE state; the memory samples the address at ack.
- `mem_enable_o` deasserts in the cycle after each ack. The one exception is WRITEBACK→ALLOCATE, where enable stays high with the new address; this is legal because the memory has returned to idle.
- The CPU holds `cpu_req_i`, address, write and data stable while `cpu_stall_o`=1. If the request drops mid-miss, the FSM still completes the sequence through FILL and then idles.

## Timing
- Reset state: FSM=IDLE, all valid=0, all dirty=0. Outputs: `cpu_stall_o`=`cpu_req_i`, `cpu_data_o`=0, all mem_* outputs=0.
- Reset mid-miss aborts immediately to IDLE; line contents are invalidated.
- Hit: 0 stall cycles.
- Memory latency is L=10 cycles from enable high to ack, inclusive.
- Clean miss (cycle 0 = detect in IDLE): ALLOCATE cycles 1–10, ack in cycle 10, FILL cycle 11, hit in cycle 12. That is 12 stall cycles (L+2).
- Dirty miss: WRITEBACK cycles 1–10, ALLOCATE 11–20, FILL 21, hit in cycle 22. That is 22 stall cycles (2L+2).
- An ack seen in IDLE or FILL is ignored.

## Test plan
- Reset, then a load from 0x0000_0040 → `cpu_stall_o`=1 for exactly 12 cycles; `mem_addr_o`=0x40, `mem_write_o`=0; after the stall, `cpu_data_o` = word 0 of the memory line.
- Repeat a load from 0x0000_0044 → no stall, and `cpu_data_o` = word 1 of the same line.
- Store 0xDEADBEEF to 0x40 → no stall. Then load from 0x240 (same index, different tag) → WRITEBACK with `mem_addr_o`=0x40 and `mem_data_o`[31:0]=0xDEADBEEF, then ALLOCATE at 0x240. Total of 22 stall cycles.
- Load from 0x40 again → clean miss and refill; `cpu_data_o`=0xDEADBEEF, which confirms memory was updated.
- Store miss to a clean line → allocate, then the store is applied in the IDLE cycle after FILL; a following load returns the stored value and the line is dirty.
- Assert rst_i low during ALLOCATE → `mem_enable_o`=0 immediately; after release, a load to the same address misses again.

Source files
------------

// File: rtl/dcache_controller_if.sv
// CPU-side and memory-side bus of the data cache, bundled so the controller,
// a CPU model and a memory model can share one set of wires.
//
// Handshake rules:
//   CPU side: cpu_req_i is held with address, write flag and store data until
//     a cycle where cpu_stall_o=0. That cycle completes the access: load data
//     is on cpu_data_o and a store commits at the closing clock edge.
//   Memory side: mem_enable_o, mem_write_o, mem_addr_o and mem_data_o are held
//     until mem_ack_i pulses for one cycle. Refill data on mem_data_i is valid
//     in the cycle after that ack.
interface dcache_controller_if #(
  parameter int LINE_BITS = 256
);
  logic                 cpu_req_i;
  logic                 cpu_write_i;
  logic [31:0]          cpu_addr_i;
  logic [31:0]          cpu_data_i;
  logic [31:0]          cpu_data_o;
  logic                 cpu_stall_o;
  logic                 mem_enable_o;
  logic                 mem_write_o;
  logic [31:0]          mem_addr_o;
  logic [LINE_BITS-1:0] mem_data_o;
  logic [LINE_BITS-1:0] mem_data_i;
  logic                 mem_ack_i;

  // Controller view: it answers the CPU and initiates memory transfers.
  modport master (
    input  cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  // Environment view: the CPU MEM stage plus the Data_Memory block.
  modport slave (
    output cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU MEM stage
// and Data_Memory. Hits finish in the same cycle; misses stall for write-back and refill.
module dcache_controller #(
  parameter int INDEX_BITS  = 4,
  parameter int LINE_BITS   = 256,
  parameter int OFFSET_BITS = 5,
  parameter int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS
) (
  input  logic                clk_i,
  input  logic                rst_i,
  dcache_controller_if.master bus,
  output logic [1:0]          dbg_state_o
);

  localparam int NUM_LINES = 1 << INDEX_BITS;
  localparam int WORD_BITS = OFFSET_BITS - 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    FILL      = 2'd3
  } state_t;

  state_t                state_q;
  logic [NUM_LINES-1:0]  valid_q;
  logic [NUM_LINES-1:0]  dirty_q;
  logic [TAG_BITS-1:0]   tag_q  [NUM_LINES];
  logic [LINE_BITS-1:0]  data_q [NUM_LINES];

  logic [TAG_BITS-1:0]   miss_tag_q;
  logic [INDEX_BITS-1:0] miss_idx_q;

  logic                  mem_enable_q;
  logic                  mem_write_q;
  logic [31:0]           mem_addr_q;
  logic [LINE_BITS-1:0]  mem_data_q;

  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] req_idx;
  logic [WORD_BITS-1:0]  req_word;
  logic                  hit;
  logic                  unused_addr_bits;

  assign req_tag  = bus.cpu_addr_i[31 -: TAG_BITS];
  assign req_idx  = bus.cpu_addr_i[OFFSET_BITS +: INDEX_BITS];
  assign req_word = bus.cpu_addr_i[2 +: WORD_BITS];
  assign unused_addr_bits = ^bus.cpu_addr_i[1:0];

  assign hit = bus.cpu_req_i && valid_q[req_idx] && (tag_q[req_idx] == req_tag)
               && (state_q == IDLE);

  assign bus.cpu_stall_o = bus.cpu_req_i && !hit;
  assign bus.cpu_data_o  = hit ? data_q[req_idx][{req_word, 5'd0} +: 32] : 32'd0;

  assign bus.mem_enable_o = mem_enable_q;
  assign bus.mem_write_o  = mem_write_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_data_o   = mem_data_q;
  assign dbg_state_o      = state_q;

  // Control FSM. The miss tag/index are latched at detection so the sequence
  // still completes correctly if the CPU drops its request mid-miss.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      miss_tag_q   <= '0;
      miss_idx_q   <= '0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit && bus.cpu_write_i) begin
            dirty_q[req_idx] <= 1'b1;
          end else if (bus.cpu_req_i && !hit) begin
            miss_tag_q   <= req_tag;
            miss_idx_q   <= req_idx;
            mem_enable_q <= 1'b1;
            if (valid_q[req_idx] && dirty_q[req_idx]) begin
              state_q     <= WRITEBACK;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {tag_q[req_idx], req_idx, {OFFSET_BITS{1'b0}}};
              mem_data_q  <= data_q[req_idx];
            end else begin
              state_q     <= ALLOCATE;
              mem_write_q <= 1'b0;
              mem_addr_q  <= {req_tag, req_idx, {OFFSET_BITS{1'b0}}};
              mem_data_q  <= '0;
            end
          end
        end
        WRITEBACK: begin
          if (bus.mem_ack_i) begin
            // Enable stays high: the memory is idle again after its ack.
            state_q     <= ALLOCATE;
            mem_write_q <= 1'b0;
            mem_addr_q  <= {miss_tag_q, miss_idx_q, {OFFSET_BITS{1'b0}}};
            mem_data_q  <= '0;
          end
        end
        ALLOCATE: begin
          if (bus.mem_ack_i) begin
            state_q      <= FILL;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
          end
        end
        FILL: begin
          state_q             <= IDLE;
          valid_q[miss_idx_q] <= 1'b1;
          dirty_q[miss_idx_q] <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Line data and tags need no reset; valid_q gates every use of them.
  always_ff @(posedge clk_i) begin
    if (state_q == FILL) begin
      data_q[miss_idx_q] <= bus.mem_data_i;
      tag_q[miss_idx_q]  <= miss_tag_q;
    end else if (hit && bus.cpu_write_i) begin
      data_q[req_idx][{req_word, 5'd0} +: 32] <= bus.cpu_data_i;
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a 10-cycle-latency line memory model.
module tb_dcache_controller;

  logic       clk_i;
  logic       rst_i;
  logic [1:0] dbg_state_o;

  dcache_controller_if #(.LINE_BITS(256)) bus ();

  dcache_controller dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .bus         (bus),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // ---------------- memory model: 64 lines, ack on 10th enabled cycle ----------------
  logic [255:0] mem [64];
  int           mem_cnt;

  initial begin
    for (int i = 0; i < 64; i++)
      for (int w = 0; w < 8; w++)
        mem[i][w*32 +: 32] = 32'hA000_0000 | (i << 8) | w;
    mem_cnt        = 0;
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
  end

  always @(negedge clk_i) begin
    if (!rst_i) begin
      mem_cnt       = 0;
      bus.mem_ack_i = 1'b0;
    end else begin
      bus.mem_ack_i = 1'b0;
      if (bus.mem_enable_o) begin
        mem_cnt = mem_cnt + 1;
        if (mem_cnt == 10) begin
          mem_cnt       = 0;
          bus.mem_ack_i = 1'b1;
          if (bus.mem_write_o) mem[bus.mem_addr_o[10:5]] = bus.mem_data_o;
          else                 bus.mem_data_i = mem[bus.mem_addr_o[10:5]];
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver: one CPU access, recording memory traffic ----------------
  logic [31:0]  wb_addr, alloc_addr;
  logic [255:0] wb_data;
  logic         wb_write, alloc_write;

  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        output int stalls, output logic [31:0] rdata);
    bus.cpu_req_i   = 1'b1;
    bus.cpu_write_i = wr;
    bus.cpu_addr_i  = addr;
    bus.cpu_data_i  = data;
    stalls = 0;
    rdata  = 32'd0;
    wb_addr = 32'd0; alloc_addr = 32'd0; wb_data = '0;
    wb_write = 1'b0; alloc_write = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_i);
      if (!bus.cpu_stall_o) begin
        rdata = bus.cpu_data_o;
        break;
      end
      stalls++;
      if (dbg_state_o == 2'd1) begin
        wb_addr  = bus.mem_addr_o;
        wb_data  = bus.mem_data_o;
        wb_write = bus.mem_write_o;
      end else if (dbg_state_o == 2'd2) begin
        alloc_addr = bus.mem_addr_o;
        if (bus.mem_write_o) alloc_write = 1'b1;
      end
    end
    @(posedge clk_i); #1;
    bus.cpu_req_i   = 1'b0;
    bus.cpu_write_i = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  int          st;
  logic [31:0] rd;

  initial begin
    rst_i           = 1'b0;
    bus.cpu_req_i   = 1'b1;
    bus.cpu_write_i = 1'b0;
    bus.cpu_addr_i  = 32'h40;
    bus.cpu_data_i  = 32'd0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_stall", bus.cpu_stall_o, 1'b1);
    chk("rst_data", bus.cpu_data_o, 32'd0);
    chk("rst_enable", bus.mem_enable_o, 1'b0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
    chk("rst_state", dbg_state_o, 2'd0);
    bus.cpu_req_i = 1'b0;
    #1;
    chk("rst_stall_noreq", bus.cpu_stall_o, 1'b0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    // Clean miss on 0x40 (memory line 2).
    access(1'b0, 32'h40, 32'd0, st, rd);
    chk("miss1_stalls", st, 12);
    chk("miss1_alloc_addr", alloc_addr, 32'h40);
    chk("miss1_alloc_write", alloc_write, 1'b0);
    chk("miss1_data", rd, 32'hA000_0200);

    access(1'b0, 32'h44, 32'd0, st, rd);
    chk("hit_stalls", st, 0);
    chk("hit_word1", rd, 32'hA000_0201);

    access(1'b1, 32'h40, 32'hDEAD_BEEF, st, rd);
    chk("store_hit_stalls", st, 0);

    // Dirty miss: same index, tag differs.
    access(1'b0, 32'h240, 32'd0, st, rd);
    chk("dirty_stalls", st, 22);
    chk("wb_addr", wb_addr, 32'h40);
    chk("wb_write", wb_write, 1'b1);
    chk("wb_word0", wb_data[31:0], 32'hDEAD_BEEF);
    chk("wb_word1", wb_data[63:32], 32'hA000_0201);
    chk("dirty_alloc_addr", alloc_addr, 32'h240);
    chk("dirty_data", rd, 32'hA000_1200);

    // 0x240 line is clean, so this is a clean miss reading back the written line.
    access(1'b0, 32'h40, 32'd0, st, rd);
    chk("reload_stalls", st, 12);
    chk("reload_data", rd, 32'hDEAD_BEEF);

    // Store miss to a clean line: allocate, then store in the following IDLE cycle.
    access(1'b1, 32'h88, 32'h1234_5678, st, rd);
    chk("store_miss_stalls", st, 12);
    chk("store_miss_alloc_addr", alloc_addr, 32'h80);
    access(1'b0, 32'h88, 32'd0, st, rd);
    chk("store_miss_load_stalls", st, 0);
    chk("store_miss_load", rd, 32'h1234_5678);
    access(1'b0, 32'h8C, 32'd0, st, rd);
    chk("store_miss_neighbour", rd, 32'hA000_0403);
    // Evicting it must write back, proving the line was dirty.
    access(1'b0, 32'h288, 32'd0, st, rd);
    chk("evict_stalls", st, 22);
    chk("evict_wb_addr", wb_addr, 32'h80);
    chk("evict_wb_word2", wb_data[95:64], 32'h1234_5678);
    chk("evict_data", rd, 32'hA000_1402);

    // Reset in the middle of ALLOCATE.
    bus.cpu_req_i   = 1'b1;
    bus.cpu_write_i = 1'b0;
    bus.cpu_addr_i  = 32'hC0;
    repeat (5) @(negedge clk_i);
    chk("pre_rst_state", dbg_state_o, 2'd2);
    chk("pre_rst_enable", bus.mem_enable_o, 1'b1);
    #2 rst_i = 1'b0;
    #1;
    chk("mid_rst_enable", bus.mem_enable_o, 1'b0);
    chk("mid_rst_state", dbg_state_o, 2'd0);
    chk("mid_rst_stall", bus.cpu_stall_o, 1'b1);
    bus.cpu_req_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    access(1'b0, 32'hC0, 32'd0, st, rd);
    chk("post_rst_stalls", st, 12);
    chk("post_rst_data", rd, 32'hA000_0600);
    access(1'b0, 32'h40, 32'd0, st, rd);
    chk("post_rst_invalid_stalls", st, 12);
    chk("post_rst_invalid_data", rd, 32'hDEAD_BEEF);

    repeat (2) @(posedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
